// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and
// the MEM-stage load/store path. Data wins by default; a streak counter
// forces fetch in after MAX_DATA_STREAK consecutive data grants while fetch
// waits. A kill suppresses the fetch response but lets the access finish.
module mem_arbiter #(
   parameter int unsigned MAX_DATA_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic [31:0] fetch_addr,
   input  logic        kill,
   output logic [31:0] fetch_data,
   output logic        fetch_data_valid,
   input  logic        dmem_req,
   input  logic        dmem_we,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata,
   input  logic [3:0]  dmem_wmask,
   output logic [31:0] dmem_rdata,
   output logic        dmem_done,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

   logic [1:0] state;
   logic [3:0] streak;
   logic       killed;
   logic       eff_fetch;
   logic       grant_fetch;
   logic       grant_data;

   assign eff_fetch = fetch_req & ~kill;

   // IDLE grant decision: data first unless fetch has waited out the streak
   always_comb begin
      grant_fetch = 1'b0;
      grant_data  = 1'b0;
      if (state == IDLE) begin
         if (dmem_req && eff_fetch && (streak == STREAK_MAX)) begin
            grant_fetch = 1'b1;
         end else if (dmem_req) begin
            grant_data = 1'b1;
         end else if (eff_fetch) begin
            grant_fetch = 1'b1;
         end
      end
   end

   // Arbiter FSM with registered memory-side and requester-side outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         streak           <= '0;
         killed           <= 1'b0;
         mem_req          <= 1'b0;
         mem_we           <= 1'b0;
         mem_addr         <= '0;
         mem_wdata        <= '0;
         mem_wmask        <= '0;
         fetch_data       <= '0;
         fetch_data_valid <= 1'b0;
         dmem_rdata       <= '0;
         dmem_done        <= 1'b0;
         busy             <= 1'b0;
      end else begin
         fetch_data_valid <= 1'b0;
         dmem_done        <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_fetch) begin
                  state     <= FETCH;
                  streak    <= '0;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= fetch_addr;
                  mem_wdata <= '0;
                  mem_wmask <= '0;
                  busy      <= 1'b1;
               end else if (grant_data) begin
                  state     <= DATA;
                  // a data grant with fetch waiting never happens at the cap
                  streak    <= eff_fetch ? streak + 4'd1 : '0;
                  mem_req   <= 1'b1;
                  mem_we    <= dmem_we;
                  mem_addr  <= dmem_addr;
                  mem_wdata <= dmem_wdata;
                  mem_wmask <= dmem_wmask;
                  busy      <= 1'b1;
               end else begin
                  streak <= '0;
               end
            end
            FETCH: begin
               if (kill) begin
                  killed <= 1'b1;
               end
               if (mem_ack) begin
                  mem_req          <= 1'b0;
                  fetch_data       <= mem_rdata;
                  fetch_data_valid <= ~(killed | kill);
                  state            <= RESP;
               end
            end
            DATA: begin
               if (mem_ack) begin
                  mem_req   <= 1'b0;
                  if (!mem_we) begin
                     dmem_rdata <= mem_rdata;
                  end
                  dmem_done <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               state  <= IDLE;
               busy   <= 1'b0;
               killed <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the arbiter kept in the bench.
module tb_mem_arbiter;

   localparam int unsigned MAXS = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        kill;
   logic [31:0] fetch_data;
   logic        fetch_data_valid;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wmask;
   logic [31:0] dmem_rdata;
   logic        dmem_done;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        busy;

   mem_arbiter #(.MAX_DATA_STREAK(MAXS)) dut (
      .clk(clk), .rst(rst),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .kill(kill),
      .fetch_data(fetch_data), .fetch_data_valid(fetch_data_valid),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
      .dmem_rdata(dmem_rdata), .dmem_done(dmem_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // model: expected outputs plus who owns the memory
   logic        e_req, e_we, e_fdv, e_done, e_busy;
   logic [31:0] e_addr, e_wdata, e_fdata, e_drdata;
   logic [3:0]  e_wmask;
   int          m_owner;        // 0 nobody, 1 fetch, 2 data
   bit          m_resp;         // response cycle in progress
   bit          m_killed;
   bit          m_wdata_known;
   int unsigned m_streak;

   // memory responder / stimulus knobs
   int unsigned waited;
   int unsigned ack_wait;
   bit          rand_mode;
   logic [31:0] next_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      e_req = 0; e_we = 0; e_fdv = 0; e_done = 0; e_busy = 0;
      e_addr = '0; e_wdata = '0; e_fdata = '0; e_drdata = '0; e_wmask = '0;
      m_owner = 0; m_resp = 0; m_killed = 0; m_wdata_known = 1; m_streak = 0;
   endtask

   task automatic model_step();
      bit eff, pick_fetch, pick_data;
      eff = fetch_req && !kill;
      if (rst) begin
         model_reset();
         return;
      end
      e_fdv = 0;
      e_done = 0;
      if (m_resp) begin
         m_resp = 0; m_owner = 0; m_killed = 0;
      end else if (m_owner == 0) begin
         pick_fetch = eff && (!dmem_req || m_streak == MAXS);
         pick_data  = dmem_req && !pick_fetch;
         if (pick_fetch) begin
            m_owner = 1; m_streak = 0; e_req = 1;
            e_addr = fetch_addr; e_we = 0; e_wmask = 0; m_wdata_known = 0;
         end else if (pick_data) begin
            m_owner = 2; e_req = 1;
            m_streak = eff ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
            e_addr = dmem_addr; e_we = dmem_we; e_wmask = dmem_wmask;
            e_wdata = dmem_wdata; m_wdata_known = 1;
         end else begin
            m_streak = 0;
         end
      end else begin
         if (m_owner == 1 && kill) m_killed = 1;
         if (mem_ack) begin
            e_req = 0; m_resp = 1;
            if (m_owner == 1) begin
               e_fdata = mem_rdata; e_fdv = !m_killed;
            end else begin
               if (!e_we) e_drdata = mem_rdata;
               e_done = 1;
            end
         end
      end
      e_busy = (m_owner != 0);
   endtask

   task automatic compare();
      chk("mem_req", mem_req, e_req);
      chk("busy", busy, e_busy);
      chk("fetch_data_valid", fetch_data_valid, e_fdv);
      chk("dmem_done", dmem_done, e_done);
      chk("fetch_data", fetch_data, e_fdata);
      chk("dmem_rdata", dmem_rdata, e_drdata);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_we", mem_we, e_we);
      chk("mem_wmask", mem_wmask, e_wmask);
      if (m_wdata_known) chk("mem_wdata", mem_wdata, e_wdata);
      chk("pulse_exclusive", fetch_data_valid & dmem_done, 0);
   endtask

   // one clock: memory response, edge, model update, compare
   task automatic step();
      if (e_req) begin
         if (waited == 0 && rand_mode) ack_wait = $urandom_range(0, 3);
         mem_ack = (waited >= ack_wait);
         waited++;
      end else begin
         waited = 0;
         mem_ack = rand_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      mem_rdata = rand_mode ? $urandom() : next_rdata;
      @(posedge clk);
      model_step();
      #1;
      compare();
   endtask

   task automatic wait_done(input string name);
      int cyc = 0;
      while (dmem_done !== 1'b1 && cyc < 20) begin step(); cyc++; end
      chk(name, dmem_done, 1);
   endtask

   task automatic wait_fdv(input string name);
      int cyc = 0;
      while (fetch_data_valid !== 1'b1 && cyc < 20) begin step(); cyc++; end
      chk(name, fetch_data_valid, 1);
   endtask

   task automatic rand_data_fields();
      dmem_we    = $urandom_range(0, 1);
      dmem_addr  = $urandom() & 32'hFFFF_FFFC;
      dmem_wdata = $urandom();
      dmem_wmask = 4'($urandom_range(0, 15));
   endtask

   task automatic drive_random();
      if (kill) begin
         kill = 0; fetch_req = 0;
      end else if (fetch_req) begin
         if (e_fdv) begin
            if ($urandom_range(0, 1) == 0) fetch_req = 0;
         end else if (!m_resp && $urandom_range(0, 11) == 0) begin
            kill = 1;
         end
      end else if ($urandom_range(0, 2) == 0) begin
         fetch_req = 1; fetch_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (dmem_req) begin
         if (e_done) begin
            if ($urandom_range(0, 1) == 0) dmem_req = 0;
            else rand_data_fields();
         end
      end else if ($urandom_range(0, 2) == 0) begin
         dmem_req = 1; rand_data_fields();
      end
   endtask

   initial begin
      logic [9:0]  seq;
      int          ngr;
      bit          prev_req, saw_fdv;
      rst = 1; fetch_req = 0; fetch_addr = '0; kill = 0;
      dmem_req = 0; dmem_we = 0; dmem_addr = '0; dmem_wdata = '0; dmem_wmask = '0;
      mem_rdata = '0; mem_ack = 0;
      rand_mode = 0; ack_wait = 0; waited = 0; next_rdata = '0;
      model_reset();
      repeat (2) step();
      chk("reset mem_req", mem_req, 0);
      chk("reset busy", busy, 0);
      chk("reset mem_addr", mem_addr, 0);
      chk("reset fetch_data", fetch_data, 0);
      rst = 0;
      step();

      // fetch only, zero-wait memory
      fetch_req = 1; fetch_addr = 32'h100; next_rdata = 32'h0050_0093;
      step();
      chk("t1 mem_req c1", mem_req, 1);
      chk("t1 mem_addr c1", mem_addr, 32'h100);
      step();
      chk("t1 valid c2", fetch_data_valid, 1);
      chk("t1 fetch_data c2", fetch_data, 32'h0050_0093);
      fetch_req = 0;
      step();
      chk("t1 busy c3", busy, 0);

      // simultaneous fetch and store: data first
      fetch_req = 1; fetch_addr = 32'h104;
      dmem_req = 1; dmem_we = 1; dmem_addr = 32'h2000; dmem_wdata = 32'hDEAD_BEEF; dmem_wmask = 4'hF;
      step();
      chk("t2 mem_we", mem_we, 1);
      chk("t2 mem_wmask", mem_wmask, 4'hF);
      chk("t2 mem_addr", mem_addr, 32'h2000);
      chk("t2 mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      step();
      chk("t2 dmem_done", dmem_done, 1);
      dmem_req = 0;
      step();
      step();
      chk("t2 fetch mem_req", mem_req, 1);
      chk("t2 fetch addr", mem_addr, 32'h104);
      chk("t2 fetch we", mem_we, 0);
      step();
      chk("t2 fetch valid", fetch_data_valid, 1);
      fetch_req = 0;
      step();

      // both held: streak cap forces fetch every fifth grant
      dmem_req = 1; dmem_we = 1; dmem_addr = 32'h3000; dmem_wdata = 32'h1; dmem_wmask = 4'hF;
      fetch_req = 1; fetch_addr = 32'h400;
      seq = '0; ngr = 0;
      for (int i = 0; i < 32; i++) begin
         prev_req = mem_req;
         step();
         if (!prev_req && mem_req && ngr < 10) begin
            seq = {seq[8:0], (mem_addr == 32'h400)};
            ngr++;
         end
      end
      chk("t3 grant count", ngr, 10);
      chk("t3 grant order", {22'd0, seq}, {22'd0, 10'b0000100001});
      dmem_req = 0; fetch_req = 0;
      repeat (4) step();

      // delayed ack with kill in the second wait cycle
      ack_wait = 3; saw_fdv = 0;
      fetch_req = 1; fetch_addr = 32'h200;
      step(); saw_fdv |= fetch_data_valid;
      step(); saw_fdv |= fetch_data_valid;
      kill = 1;
      step(); saw_fdv |= fetch_data_valid;
      kill = 0; fetch_req = 0;
      step(); saw_fdv |= fetch_data_valid;
      chk("t4 mem_req in ack cycle", mem_req, 1);
      step(); saw_fdv |= fetch_data_valid;
      chk("t4 resp busy", busy, 1);
      step(); saw_fdv |= fetch_data_valid;
      chk("t4 idle busy", busy, 0);
      chk("t4 valid never", saw_fdv, 0);
      ack_wait = 0;

      // load then store: store leaves dmem_rdata alone
      ack_wait = 1;
      dmem_req = 1; dmem_we = 0; dmem_addr = 32'h40; next_rdata = 32'h1234_5678;
      wait_done("t5 load done");
      chk("t5 load rdata", dmem_rdata, 32'h1234_5678);
      dmem_req = 0;
      step();
      dmem_req = 1; dmem_we = 1; dmem_addr = 32'h44; dmem_wdata = 32'h55; dmem_wmask = 4'h3;
      next_rdata = 32'hCAFE_F00D;
      wait_done("t5 store done");
      chk("t5 rdata kept", dmem_rdata, 32'h1234_5678);
      dmem_req = 0;
      step();
      ack_wait = 0;

      // asynchronous reset in the middle of a data access
      ack_wait = 5;
      dmem_req = 1; dmem_we = 1; dmem_addr = 32'h5000; dmem_wdata = 32'hA5A5_A5A5; dmem_wmask = 4'hC;
      step();
      step();
      chk("t6 pre mem_req", mem_req, 1);
      #2;
      rst = 1;
      #1;
      chk("t6 rst mem_req", mem_req, 0);
      chk("t6 rst mem_we", mem_we, 0);
      chk("t6 rst mem_addr", mem_addr, 0);
      chk("t6 rst mem_wdata", mem_wdata, 0);
      chk("t6 rst mem_wmask", mem_wmask, 0);
      chk("t6 rst fetch_data", fetch_data, 0);
      chk("t6 rst fetch_valid", fetch_data_valid, 0);
      chk("t6 rst dmem_rdata", dmem_rdata, 0);
      chk("t6 rst dmem_done", dmem_done, 0);
      chk("t6 rst busy", busy, 0);
      model_reset();
      waited = 0; ack_wait = 0; dmem_req = 0;
      step();
      rst = 0;
      fetch_req = 1; fetch_addr = 32'h300; next_rdata = 32'h00A0_0113;
      wait_fdv("t6 fetch after reset");
      chk("t6 fetch data", fetch_data, 32'h00A0_0113);
      fetch_req = 0;
      step();

      // randomized traffic
      rand_mode = 1;
      repeat (3000) begin
         drive_random();
         step();
      end
      rand_mode = 0; ack_wait = 0;
      fetch_req = 0; dmem_req = 0; kill = 0;
      repeat (10) step();
      chk("drain busy", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
